// File: rtl/mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_access_unit
//
// MEM pipeline stage. Consumes the EX/MEM register bundle, resolves branches
// combinationally, runs load/store accesses to data memory over a req/ack
// handshake that may last several cycles, stalls the front of the pipeline
// while an access is outstanding, and drives the MEM/WB register.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   EX_MEM_*                   EX/MEM register contents (WB/M controls, branch
//                              target, ALU result, store data, dest reg, zero)
//   mem_ack, mem_rdata         memory completion pulse and load data
//   mem_req, mem_we,
//   mem_addr, mem_wdata        registered memory request (word-aligned address)
//   PCSrc, branch_target       combinational branch decision and target
//   stall                      freezes PC, IF/ID, ID/EX and EX/MEM
//   mem_error                  sticky: access timed out or was misaligned
//   MEM_WB_*                   registered MEM/WB contents for write-back
// -----------------------------------------------------------------------------
module mem_stage_access_unit #(
   parameter int TIMEOUT = 16,  // max WAIT cycles without ack (1..255)
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  EX_MEM_WB,
   input  logic [2:0]  EX_MEM_M,
   input  logic [31:0] EX_MEM_branch_address,
   input  logic [31:0] EX_MEM_alu_result,
   input  logic [31:0] EX_MEM_read_data_2,
   input  logic [4:0]  EX_MEM_write_address,
   input  logic        EX_MEM_zero_flag,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        PCSrc,
   output logic [31:0] branch_target,
   output logic        stall,
   output logic        mem_error,
   output logic [1:0]  MEM_WB_WB,
   output logic [31:0] MEM_WB_read_data,
   output logic [31:0] MEM_WB_alu_result,
   output logic [4:0]  MEM_WB_write_address
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              mem_error_q, mem_error_d;
   logic [1:0]        wb_ctl_q, wb_ctl_d;
   logic [31:0]       wb_rdata_q, wb_rdata_d;
   logic [31:0]       wb_alu_q, wb_alu_d;
   logic [4:0]        wb_waddr_q, wb_waddr_d;

   logic access;

   assign access = EX_MEM_M[1] | EX_MEM_M[0];

   // Branch resolution is independent of the memory handshake.
   assign PCSrc         = EX_MEM_M[2] & EX_MEM_zero_flag;
   assign branch_target = EX_MEM_branch_address;

   // DONE does not stall: EX/MEM advances on that edge, so the finished
   // operation is gone before the FSM is back in IDLE.
   assign stall = ((state_q == S_IDLE) && access) || (state_q == S_WAIT);

   // Access FSM and memory request registers.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      rbuf_d      = rbuf_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_error_d = mem_error_q;

      case (state_q)
         S_IDLE: begin
            if (access) begin
               mem_req_d   = 1'b1;
               mem_we_d    = EX_MEM_M[0];  // write wins when both bits are set
               mem_addr_d  = {EX_MEM_alu_result[31:2], 2'b00};
               mem_wdata_d = EX_MEM_read_data_2;
               cnt_d       = '0;
               state_d     = S_WAIT;
               // Misalignment is flagged but the aligned word is still accessed.
               if (EX_MEM_alu_result[1:0] != 2'b00) mem_error_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               rbuf_d    = mem_we_q ? 32'd0 : mem_rdata;
               state_d   = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d   = 1'b0;
               rbuf_d      = 32'd0;
               mem_error_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // MEM/WB register: bubble the controls while stalled, hold the data fields.
   always_comb begin
      wb_ctl_d   = wb_ctl_q;
      wb_rdata_d = wb_rdata_q;
      wb_alu_d   = wb_alu_q;
      wb_waddr_d = wb_waddr_q;

      if (stall) begin
         wb_ctl_d = 2'b00;
      end else begin
         wb_ctl_d   = EX_MEM_WB;
         wb_alu_d   = EX_MEM_alu_result;
         wb_waddr_d = EX_MEM_write_address;
         wb_rdata_d = (state_q == S_DONE) ? rbuf_q : 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rbuf_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_error_q <= 1'b0;
         wb_ctl_q    <= '0;
         wb_rdata_q  <= '0;
         wb_alu_q    <= '0;
         wb_waddr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rbuf_q      <= rbuf_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_error_q <= mem_error_d;
         wb_ctl_q    <= wb_ctl_d;
         wb_rdata_q  <= wb_rdata_d;
         wb_alu_q    <= wb_alu_d;
         wb_waddr_q  <= wb_waddr_d;
      end
   end

   assign mem_req              = mem_req_q;
   assign mem_we               = mem_we_q;
   assign mem_addr             = mem_addr_q;
   assign mem_wdata            = mem_wdata_q;
   assign mem_error            = mem_error_q;
   assign MEM_WB_WB            = wb_ctl_q;
   assign MEM_WB_read_data     = wb_rdata_q;
   assign MEM_WB_alu_result    = wb_alu_q;
   assign MEM_WB_write_address = wb_waddr_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_access_unit
//
// Directed bench for the MEM stage: a table of single-cycle (non-memory and
// branch) vectors, then hand-written sequences for reset during WAIT, load,
// store, misaligned access, back-to-back accesses and timeout (TIMEOUT=4).
// -----------------------------------------------------------------------------
module tb_mem_stage_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  EX_MEM_WB;
   logic [2:0]  EX_MEM_M;
   logic [31:0] EX_MEM_branch_address;
   logic [31:0] EX_MEM_alu_result;
   logic [31:0] EX_MEM_read_data_2;
   logic [4:0]  EX_MEM_write_address;
   logic        EX_MEM_zero_flag;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_req, mem_we, PCSrc, stall, mem_error;
   logic [31:0] mem_addr, mem_wdata, branch_target;
   logic [1:0]  MEM_WB_WB;
   logic [31:0] MEM_WB_read_data, MEM_WB_alu_result;
   logic [4:0]  MEM_WB_write_address;

   int errors = 0;
   int checks = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;

   mem_stage_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .EX_MEM_WB             (EX_MEM_WB),
      .EX_MEM_M              (EX_MEM_M),
      .EX_MEM_branch_address (EX_MEM_branch_address),
      .EX_MEM_alu_result     (EX_MEM_alu_result),
      .EX_MEM_read_data_2    (EX_MEM_read_data_2),
      .EX_MEM_write_address  (EX_MEM_write_address),
      .EX_MEM_zero_flag      (EX_MEM_zero_flag),
      .mem_ack               (mem_ack),
      .mem_rdata             (mem_rdata),
      .mem_req               (mem_req),
      .mem_we                (mem_we),
      .mem_addr              (mem_addr),
      .mem_wdata             (mem_wdata),
      .PCSrc                 (PCSrc),
      .branch_target         (branch_target),
      .stall                 (stall),
      .mem_error             (mem_error),
      .MEM_WB_WB             (MEM_WB_WB),
      .MEM_WB_read_data      (MEM_WB_read_data),
      .MEM_WB_alu_result     (MEM_WB_alu_result),
      .MEM_WB_write_address  (MEM_WB_write_address)
   );

   always #5 clk = ~clk;

   // Counts request issues, sampled away from the active edge.
   always @(negedge clk) begin
      if (mem_req && !req_prev) req_rises++;
      req_prev = mem_req;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [31:0] baddr;
      logic [31:0] alu;
      logic [4:0]  waddr;
      logic        zero;
      logic        exp_pcsrc;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] baddr,
                         input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] waddr,
                         input logic zero);
      EX_MEM_WB             = wb;
      EX_MEM_M              = m;
      EX_MEM_branch_address = baddr;
      EX_MEM_alu_result     = alu;
      EX_MEM_read_data_2    = rd2;
      EX_MEM_write_address  = waddr;
      EX_MEM_zero_flag      = zero;
   endtask

   task automatic nop();
      set_ex(2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   initial begin
      reset   = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      nop();
      tick();
      tick();
      reset = 1'b0;
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      check("reset mem_error", 32'(mem_error), 32'd0);
      check("reset MEM_WB_WB", 32'(MEM_WB_WB), 32'd0);
      check("reset MEM_WB_read_data", MEM_WB_read_data, 32'd0);

      // ---------------- single-cycle vectors (no memory access) ------------
      vecs[0] = '{2'b10, 3'b000, 32'h0000_0100, 32'h0000_1234, 5'd3,  1'b0, 1'b0};
      vecs[1] = '{2'b00, 3'b100, 32'h0000_0400, 32'h0000_0000, 5'd0,  1'b1, 1'b1};
      vecs[2] = '{2'b00, 3'b100, 32'h0000_0400, 32'h0000_0007, 5'd0,  1'b0, 1'b0};
      vecs[3] = '{2'b10, 3'b000, 32'h0000_0800, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0};
      vecs[4] = '{2'b01, 3'b100, 32'h0000_0008, 32'h0000_0055, 5'd1,  1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         set_ex(vecs[i].wb, vecs[i].m, vecs[i].baddr, vecs[i].alu, 32'hA5A5_0000,
                vecs[i].waddr, vecs[i].zero);
         #1;
         check($sformatf("vec%0d PCSrc", i), 32'(PCSrc), 32'(vecs[i].exp_pcsrc));
         check($sformatf("vec%0d branch_target", i), branch_target, vecs[i].baddr);
         check($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
         tick();
         check($sformatf("vec%0d MEM_WB_WB", i), 32'(MEM_WB_WB), 32'(vecs[i].wb));
         check($sformatf("vec%0d MEM_WB_alu_result", i), MEM_WB_alu_result, vecs[i].alu);
         check($sformatf("vec%0d MEM_WB_write_address", i), 32'(MEM_WB_write_address), 32'(vecs[i].waddr));
         check($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'd0);
      end

      // ---------------- reset asserted mid-WAIT ----------------------------
      set_ex(2'b11, 3'b010, 32'd0, 32'h0000_0013, 32'd0, 5'd4, 1'b0);
      tick();
      check("rstwait mem_req", 32'(mem_req), 32'd1);
      check("rstwait mem_error set", 32'(mem_error), 32'd1);
      tick();
      reset = 1'b1;
      nop();
      tick();
      tick();
      reset = 1'b0;
      check("rstwait mem_req after", 32'(mem_req), 32'd0);
      check("rstwait stall after", 32'(stall), 32'd0);
      check("rstwait MEM_WB_WB after", 32'(MEM_WB_WB), 32'd0);
      check("rstwait mem_error after", 32'(mem_error), 32'd0);
      tick();
      check("rstwait no reissue", 32'(mem_req), 32'd0);

      // ---------------- load, ack in third WAIT cycle ----------------------
      set_ex(2'b11, 3'b010, 32'd0, 32'h0000_0010, 32'd0, 5'd8, 1'b0);
      #1;
      check("load stall idle", 32'(stall), 32'd1);
      check("load MEM_WB_WB prev", 32'(MEM_WB_WB), 32'd0);
      tick();                              // WAIT 1
      check("load req w1", 32'(mem_req), 32'd1);
      check("load we", 32'(mem_we), 32'd0);
      check("load addr", mem_addr, 32'h0000_0010);
      check("load stall w1", 32'(stall), 32'd1);
      check("load bubble", 32'(MEM_WB_WB), 32'd0);
      tick();                              // WAIT 2
      check("load req w2", 32'(mem_req), 32'd1);
      check("load stall w2", 32'(stall), 32'd1);
      tick();                              // WAIT 3
      check("load req w3", 32'(mem_req), 32'd1);
      check("load stall w3", 32'(stall), 32'd1);
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();                              // DONE
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      check("load req done", 32'(mem_req), 32'd0);
      check("load stall done", 32'(stall), 32'd0);
      tick();                              // EX/MEM advances here
      nop();
      check("load MEM_WB_read_data", MEM_WB_read_data, 32'hDEAD_BEEF);
      check("load MEM_WB_WB", 32'(MEM_WB_WB), 32'd3);
      check("load MEM_WB_write_address", 32'(MEM_WB_write_address), 32'd8);
      check("load mem_error", 32'(mem_error), 32'd0);

      // ack outside WAIT is ignored
      mem_ack = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 1'b0;
      check("stray ack read_data", MEM_WB_read_data, 32'd0);
      check("stray ack mem_req", 32'(mem_req), 32'd0);

      // ---------------- store, immediate ack --------------------------------
      set_ex(2'b00, 3'b001, 32'd0, 32'h0000_0024, 32'h1234_5678, 5'd0, 1'b0);
      tick();                              // WAIT
      check("store we", 32'(mem_we), 32'd1);
      check("store addr", mem_addr, 32'h0000_0024);
      check("store wdata", mem_wdata, 32'h1234_5678);
      mem_ack = 1'b1;
      mem_rdata = 32'hAAAA_BBBB;
      tick();                              // DONE
      mem_ack = 1'b0;
      check("store stall done", 32'(stall), 32'd0);
      tick();                              // third edge: MEM/WB updated
      nop();
      check("store MEM_WB_read_data", MEM_WB_read_data, 32'd0);
      check("store MEM_WB_alu_result", MEM_WB_alu_result, 32'h0000_0024);

      // ---------------- misaligned load ------------------------------------
      set_ex(2'b10, 3'b010, 32'd0, 32'h0000_0013, 32'd0, 5'd9, 1'b0);
      tick();
      check("misal addr", mem_addr, 32'h0000_0010);
      check("misal mem_error", 32'(mem_error), 32'd1);
      mem_ack = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0;
      tick();
      nop();
      check("misal read_data", MEM_WB_read_data, 32'hCAFE_F00D);
      check("misal alu_result", MEM_WB_alu_result, 32'h0000_0013);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("clear mem_error", 32'(mem_error), 32'd0);

      // ---------------- back-to-back load then store ------------------------
      req_rises = 0;
      set_ex(2'b11, 3'b010, 32'd0, 32'h0000_0080, 32'd0, 5'd2, 1'b0);
      tick();                              // WAIT
      mem_ack = 1'b1;
      mem_rdata = 32'h1111_2222;
      tick();                              // DONE
      mem_ack = 1'b0;
      check("b2b req done", 32'(mem_req), 32'd0);
      tick();                              // IDLE with the store presented
      set_ex(2'b00, 3'b011, 32'd0, 32'h0000_0084, 32'h3333_4444, 5'd0, 1'b0);
      #1;
      check("b2b load read_data", MEM_WB_read_data, 32'h1111_2222);
      check("b2b req idle", 32'(mem_req), 32'd0);
      check("b2b stall idle", 32'(stall), 32'd1);
      tick();
      check("b2b req rises", 32'(mem_req), 32'd1);
      check("b2b both-bits is write", 32'(mem_we), 32'd1);
      check("b2b addr", mem_addr, 32'h0000_0084);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      nop();
      check("b2b store read_data", MEM_WB_read_data, 32'd0);
      tick();
      tick();
      check("b2b issue count", 32'(req_rises), 32'd2);

      // ---------------- timeout (TIMEOUT=4) ---------------------------------
      set_ex(2'b11, 3'b010, 32'd0, 32'h0000_0040, 32'd0, 5'd5, 1'b0);
      tick();                              // WAIT 1
      check("to req w1", 32'(mem_req), 32'd1);
      tick();
      tick();
      tick();                              // WAIT 4
      check("to req w4", 32'(mem_req), 32'd1);
      check("to error w4", 32'(mem_error), 32'd0);
      tick();                              // DONE
      check("to req dropped", 32'(mem_req), 32'd0);
      check("to mem_error", 32'(mem_error), 32'd1);
      check("to stall done", 32'(stall), 32'd0);
      tick();
      nop();
      check("to read_data", MEM_WB_read_data, 32'd0);
      check("to MEM_WB_WB", 32'(MEM_WB_WB), 32'd3);
      check("to write_address", 32'(MEM_WB_write_address), 32'd5);
      tick();
      check("to error sticky", 32'(mem_error), 32'd1);
      check("to resumes", 32'(stall), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
